// File: rtl/eeprom_burst_sched.sv
// eeprom_burst_sched: splits user read/write requests into I2C EEPROM engine
// transactions, cutting writes at page boundaries and holding off bus access
// until the internal write cycle (tWR) of the last page write has elapsed.
module eeprom_burst_sched #(
  parameter int unsigned PAGE_SIZE  = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned TWR_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        wdata,
  output logic              wdata_ready,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              busy,
  // engine side
  output logic              eng_req,
  output logic              eng_rd,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LEN_W-1:0]  eng_len,
  input  logic              eng_ack,
  input  logic              eng_wpop,
  output logic [7:0]        eng_wdata,
  input  logic              eng_rvalid,
  input  logic [7:0]        eng_rdata,
  input  logic              eng_done,
  input  logic              eng_nack
);

  localparam int unsigned TWR_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_rd;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic [LEN_W-1:0]    r_chunk;
  logic [TWR_W-1:0]    r_twr_cnt;
  logic                r_err;
  logic                r_rdata_valid;
  logic [7:0]          r_rdata;

  logic [LEN_W-1:0]    w_page_off;
  logic [LEN_W-1:0]    w_page_room;
  logic [LEN_W-1:0]    w_chunk;
  logic                w_accept;
  logic                w_run_done;
  logic                w_in_run;

  // Chunk size: reads go in one sequential transaction, writes stop at the page end
  always_comb begin
    w_page_off  = LEN_W'(r_cur_addr & ADDR_W'(PAGE_SIZE - 1));
    w_page_room = LEN_W'(PAGE_SIZE) - w_page_off;
    if (r_rd) begin
      w_chunk = r_remaining;
    end else if (r_remaining < w_page_room) begin
      w_chunk = r_remaining;
    end else begin
      w_chunk = w_page_room;
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_in_run   = (r_state == ST_RUN);
  assign w_run_done = w_in_run && eng_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero-length command passes through GAP so that
  // accept-to-done latency matches the two-cycle command turnaround
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_remaining == '0) begin
          w_state_nxt = ST_FIN;
        end else if (r_twr_cnt == '0) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (eng_ack) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (eng_done) begin
          if (eng_nack || (r_remaining == r_chunk)) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    eng_req     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    wdata_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_GAP: begin
        busy = 1'b1;
      end
      ST_ISSUE: begin
        busy    = 1'b1;
        eng_req = 1'b1;
      end
      ST_RUN: begin
        busy        = 1'b1;
        wdata_ready = eng_wpop;
      end
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
        err  = r_err;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Command context: address/length bookkeeping and the abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd        <= 1'b0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd        <= cmd_rd;
        r_cur_addr  <= cmd_addr;
        r_remaining <= cmd_len;
        r_err       <= 1'b0;
      end
      // Descriptor is frozen from here until the transaction completes
      if ((r_state == ST_GAP) && (w_state_nxt == ST_ISSUE)) begin
        r_chunk <= w_chunk;
      end
      if (w_run_done) begin
        if (eng_nack) begin
          r_err <= 1'b1;
        end else begin
          r_cur_addr  <= r_cur_addr + ADDR_W'(r_chunk);
          r_remaining <= r_remaining - r_chunk;
        end
      end
      if (r_state == ST_FIN) begin
        r_err <= 1'b0;
      end
    end
  end

  // tWR countdown; runs in every state and outlives the command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_twr_cnt <= '0;
    end else if (w_run_done && !eng_nack && !r_rd) begin
      r_twr_cnt <= TWR_W'(TWR_CYCLES);
    end else if (r_twr_cnt != '0) begin
      r_twr_cnt <= r_twr_cnt - TWR_W'(1);
    end
  end

  // Read byte forwarding, one cycle behind the engine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= w_in_run && eng_rvalid;
      if (w_in_run && eng_rvalid) begin
        r_rdata <= eng_rdata;
      end
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign eng_rd      = r_rd;
  assign eng_addr    = r_cur_addr;
  assign eng_len     = r_chunk;
  assign eng_wdata   = wdata;

endmodule

// File: tb/tb_eeprom_burst_sched.sv
// Directed bench for eeprom_burst_sched with a 3-cycle-ack engine model.
module tb_eeprom_burst_sched;

  localparam int unsigned PAGE_SIZE  = 8;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned TWR_CYCLES = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [7:0]        wdata;
  logic              wdata_ready;
  logic [7:0]        rdata;
  logic              rdata_valid;
  logic              done;
  logic              err;
  logic              busy;
  logic              eng_req;
  logic              eng_rd;
  logic [ADDR_W-1:0] eng_addr;
  logic [LEN_W-1:0]  eng_len;
  logic              eng_ack;
  logic              eng_wpop;
  logic [7:0]        eng_wdata;
  logic              eng_rvalid;
  logic [7:0]        eng_rdata;
  logic              eng_done;
  logic              eng_nack;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_pops = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eeprom_burst_sched #(
    .PAGE_SIZE  (PAGE_SIZE),
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .TWR_CYCLES (TWR_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rd      (cmd_rd),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .eng_req     (eng_req),
    .eng_rd      (eng_rd),
    .eng_addr    (eng_addr),
    .eng_len     (eng_len),
    .eng_ack     (eng_ack),
    .eng_wpop    (eng_wpop),
    .eng_wdata   (eng_wdata),
    .eng_rvalid  (eng_rvalid),
    .eng_rdata   (eng_rdata),
    .eng_done    (eng_done),
    .eng_nack    (eng_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic rd, input logic [15:0] addr, input logic [7:0] len,
                       output int t_acc);
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_addr  = addr;
    cmd_len   = len;
    t_acc     = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget, output int t_req);
    int k;
    k = 0;
    while ((eng_req !== 1'b1) && (k < budget)) begin
      tick();
      k++;
    end
    chk("eng_req_seen", 32'(eng_req), 32'd1);
    t_req = cyc;
  endtask

  // Engine model: ack 3 cycles after request, move len bytes, then done
  task automatic txn(input logic rd, input logic [15:0] addr, input logic [7:0] len,
                     input logic nack, output int t_req, output int t_done);
    logic [7:0] b;
    wait_req(200, t_req);
    chk("eng_rd", 32'(eng_rd), 32'(rd));
    chk("eng_addr", 32'(eng_addr), 32'(addr));
    chk("eng_len", 32'(eng_len), 32'(len));
    tick(3);
    chk("eng_req_held", 32'(eng_req), 32'd1);
    chk("eng_addr_stable", 32'(eng_addr), 32'(addr));
    eng_ack = 1'b1;
    tick();
    eng_ack = 1'b0;
    chk("eng_req_drop_after_ack", 32'(eng_req), 32'd0);
    for (int i = 0; i < int'(len); i++) begin
      if (rd) begin
        b          = 8'(32'hA0 + i);
        eng_rvalid = 1'b1;
        eng_rdata  = b;
        tick();
        eng_rvalid = 1'b0;
        chk("rdata_valid", 32'(rdata_valid), 32'd1);
        chk("rdata", 32'(rdata), 32'(b));
      end else begin
        b        = 8'(32'h50 + i);
        eng_wpop = 1'b1;
        wdata    = b;
        #1;
        if (wdata_ready === 1'b1) n_pops++;
        chk("eng_wdata", 32'(eng_wdata), 32'(b));
        tick();
        eng_wpop = 1'b0;
      end
    end
    eng_done = 1'b1;
    eng_nack = nack;
    t_done   = cyc;
    tick();
    eng_done = 1'b0;
    eng_nack = 1'b0;
  endtask

  task automatic finish_cmd(input logic exp_err);
    chk("done_pulse", 32'(done), 32'd1);
    chk("err_with_done", 32'(err), 32'(exp_err));
    chk("busy_at_done", 32'(busy), 32'd1);
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    int ta, tr, td, tr2, td2;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_rd     = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    wdata      = '0;
    eng_ack    = 1'b0;
    eng_wpop   = 1'b0;
    eng_rvalid = 1'b0;
    eng_rdata  = '0;
    eng_done   = 1'b0;
    eng_nack   = 1'b0;

    // Reset values
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eng_req", 32'(eng_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_eng_len", 32'(eng_len), 32'd0);
    chk("rst_eng_addr", 32'(eng_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Write 0x0005 len 10: page split into (5,3) and (8,7) with tWR between
    n_pops = 0;
    issue(1'b0, 16'h0005, 8'd10, ta);
    txn(1'b0, 16'h0005, 8'd3, 1'b0, tr, td);
    chk("w1_first_req_latency", 32'(tr - ta), 32'd2);
    chk("w1_no_done_mid", 32'(done), 32'd0);
    txn(1'b0, 16'h0008, 8'd7, 1'b0, tr2, td2);
    chk("w1_twr_gap_ge21", 32'((tr2 - td) >= 21), 32'd1);
    finish_cmd(1'b0);
    chk("w1_wdata_ready_pulses", 32'(n_pops), 32'd10);
    tick(25);

    // Read 0x00FE len 4: one transaction across the page boundary
    issue(1'b1, 16'h00FE, 8'd4, ta);
    txn(1'b1, 16'h00FE, 8'd4, 1'b0, tr, td);
    chk("r1_req_latency", 32'(tr - ta), 32'd2);
    finish_cmd(1'b0);
    tick(2);

    // Write 0xFFFE len 4: address wraps to 0x0000
    issue(1'b0, 16'hFFFE, 8'd4, ta);
    txn(1'b0, 16'hFFFE, 8'd2, 1'b0, tr, td);
    txn(1'b0, 16'h0000, 8'd2, 1'b0, tr2, td2);
    finish_cmd(1'b0);
    tick(25);

    // Write 0x0010 len 8, then a read right after done waits out tWR
    issue(1'b0, 16'h0010, 8'd8, ta);
    txn(1'b0, 16'h0010, 8'd8, 1'b0, tr, td);
    finish_cmd(1'b0);
    issue(1'b1, 16'h0030, 8'd1, ta);
    txn(1'b1, 16'h0030, 8'd1, 1'b0, tr2, td2);
    chk("w4_read_after_twr", 32'((tr2 - td) >= 20), 32'd1);
    finish_cmd(1'b0);
    tick(25);

    // Write 0x0006 len 12, NACK on second chunk aborts the command
    issue(1'b0, 16'h0006, 8'd12, ta);
    txn(1'b0, 16'h0006, 8'd2, 1'b0, tr, td);
    txn(1'b0, 16'h0008, 8'd8, 1'b1, tr2, td2);
    chk("nack_no_third_req", 32'(eng_req), 32'd0);
    finish_cmd(1'b1);
    chk("nack_no_req_after", 32'(eng_req), 32'd0);
    issue(1'b1, 16'h0040, 8'd2, ta);
    txn(1'b1, 16'h0040, 8'd2, 1'b0, tr, td);
    chk("nack_twr_not_armed", 32'(tr - ta), 32'd2);
    finish_cmd(1'b0);
    tick(2);

    // Zero-length command: done at accept+2, never a request
    issue(1'b0, 16'h0123, 8'd0, ta);
    chk("len0_no_done_t1", 32'(done), 32'd0);
    chk("len0_no_req_t1", 32'(eng_req), 32'd0);
    chk("len0_busy_t1", 32'(busy), 32'd1);
    tick();
    chk("len0_done_latency", 32'(cyc - ta), 32'd2);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_err", 32'(err), 32'd0);
    chk("len0_no_req_t2", 32'(eng_req), 32'd0);
    tick();
    chk("len0_back_idle", 32'(cmd_ready), 32'd1);

    // Reset asserted while a write transaction is running
    issue(1'b0, 16'h0020, 8'd3, ta);
    wait_req(50, tr);
    tick(3);
    eng_ack = 1'b1;
    tick();
    eng_ack = 1'b0;
    eng_wpop = 1'b1;
    #1;
    chk("mid_wdata_ready", 32'(wdata_ready), 32'd1);
    tick();
    eng_wpop = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_eng_req", 32'(eng_req), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_eng_len", 32'(eng_len), 32'd0);
    chk("mrst_eng_addr", 32'(eng_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_done", 32'(done), 32'd0);
    end

    // Recovery after reset
    issue(1'b1, 16'h0050, 8'd1, ta);
    txn(1'b1, 16'h0050, 8'd1, 1'b0, tr, td);
    chk("recover_req_latency", 32'(tr - ta), 32'd2);
    finish_cmd(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
